// File: rtl/keccak_pkg.sv
// Shared constants and state encoding for the Keccak absorb-side padder.
package keccak_pkg;

  localparam int K_RATE  = 1088;
  localparam int K_WORDS = K_RATE / 64;

  localparam logic [7:0] PAD_KECCAK = 8'h01;
  localparam logic [7:0] PAD_SHA3   = 8'h06;
  localparam logic [7:0] PAD_END    = 8'h80;

  // FILL: accepting words; ZERO_FILL: padding the rest of the final block;
  // FULL: block presented to the permutation; DONE: message finished.
  typedef enum logic [1:0] {
    FILL      = 2'd0,
    ZERO_FILL = 2'd1,
    FULL      = 2'd2,
    DONE      = 2'd3
  } pad_state_e;

endpackage

// File: rtl/keccak_pad_word.sv
// Last-word transform: keep the valid leading bytes, insert the pad-start
// byte right after them, and clear everything beyond it. Byte 0 is the MSB.
module keccak_pad_word
  import keccak_pkg::*;
#(
  parameter logic [7:0] PAD_BYTE = PAD_KECCAK
) (
  input  logic [63:0] i_word,
  input  logic [2:0]  i_byte_num,
  output logic [63:0] o_word
);

  // Per-byte select: pass, pad byte, or zero.
  always_comb begin
    o_word = '0;
    for (int b = 0; b < 8; b++) begin
      if (3'(b) < i_byte_num) begin
        o_word[63-8*b -: 8] = i_word[63-8*b -: 8];
      end else if (3'(b) == i_byte_num) begin
        o_word[63-8*b -: 8] = PAD_BYTE;
      end
    end
  end

endmodule

// File: rtl/keccak_padder.sv
// Packs 64-bit message words into RATE-bit blocks, applies Keccak multi-rate
// padding to the final block, and holds each block until the permutation acks.
module keccak_padder
  import keccak_pkg::*;
#(
  parameter int         RATE     = K_RATE,
  parameter logic [7:0] PAD_BYTE = PAD_KECCAK
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [63:0]     in,
  input  logic            in_ready,
  input  logic            is_last,
  input  logic [2:0]      byte_num,
  output logic            buffer_full,
  output logic [RATE-1:0] out,
  output logic            out_ready,
  input  logic            f_ack,
  output logic            done
);

  localparam int WORDS = RATE / 64;
  localparam int CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORDS - 1);

  pad_state_e      r_state;
  pad_state_e      w_next_state;
  logic [CNT_W-1:0] r_cnt;
  logic [RATE-1:0] r_out;
  logic            r_last_blk;

  logic            w_accept;
  logic            w_cnt_last;
  logic            w_end_mark;
  logic            w_shift_en;
  logic [63:0]     w_pad_word;
  logic [63:0]     w_in_word;
  logic [63:0]     w_shift_word;
  logic [RATE-1:0] w_shifted;

  keccak_pad_word #(
    .PAD_BYTE (PAD_BYTE)
  ) u_pad_word (
    .i_word     (in),
    .i_byte_num (byte_num),
    .o_word     (w_pad_word)
  );

  assign w_accept   = in_ready && (r_state == FILL);
  assign w_cnt_last = (r_cnt == LAST_IDX);
  assign w_shift_en = w_accept || (r_state == ZERO_FILL);

  // The closing 0x80 lands on the last word of the final block, whether that
  // word is the message's own last word or a zero-fill word.
  assign w_end_mark = w_cnt_last &&
                      (((r_state == FILL) && is_last) || (r_state == ZERO_FILL));

  assign w_in_word    = (r_state == FILL) ? (is_last ? w_pad_word : in) : 64'h0;
  assign w_shift_word = w_in_word | {56'h0, (w_end_mark ? PAD_END : 8'h00)};

  generate
    if (WORDS > 1) begin : g_shift
      assign w_shifted = {r_out[RATE-65:0], w_shift_word};
    end else begin : g_single
      assign w_shifted = w_shift_word;
    end
  endgenerate

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= FILL;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      FILL: begin
        if (w_accept) begin
          if (w_cnt_last) begin
            w_next_state = FULL;
          end else if (is_last) begin
            w_next_state = ZERO_FILL;
          end
        end
      end
      ZERO_FILL: begin
        if (w_cnt_last) begin
          w_next_state = FULL;
        end
      end
      FULL: begin
        if (f_ack) begin
          w_next_state = r_last_blk ? DONE : FILL;
        end
      end
      DONE: begin
        w_next_state = DONE;
      end
      default: begin
        w_next_state = FILL;
      end
    endcase
  end

  // Outputs decoded from state.
  always_comb begin
    buffer_full = (r_state != FILL);
    out_ready   = (r_state == FULL);
    done        = (r_state == DONE);
  end

  // Block shift register, word counter and final-block flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt      <= '0;
      r_out      <= '0;
      r_last_blk <= 1'b0;
    end else begin
      if (w_shift_en) begin
        r_out <= w_shifted;
        r_cnt <= w_cnt_last ? '0 : r_cnt + 1'b1;
      end else if ((r_state == FULL) && f_ack) begin
        r_out <= '0;
      end
      if (w_accept && is_last) begin
        r_last_blk <= 1'b1;
      end
    end
  end

  assign out = r_out;

endmodule

// File: tb/tb_keccak_padder.sv
// Directed bench for keccak_padder at default RATE=1088, PAD_BYTE=8'h01.
module tb_keccak_padder;

  localparam logic [63:0] ONES1 = 64'h1111_1111_1111_1111;

  logic          clk;
  logic          tb_reset;
  logic [63:0]   tb_in;
  logic          tb_in_ready;
  logic          tb_is_last;
  logic [2:0]    tb_byte_num;
  logic          tb_buffer_full;
  logic [1087:0] tb_out;
  logic          tb_out_ready;
  logic          tb_f_ack;
  logic          tb_done;

  int errors = 0;
  int checks = 0;

  keccak_padder dut (
    .clk         (clk),
    .reset       (tb_reset),
    .in          (tb_in),
    .in_ready    (tb_in_ready),
    .is_last     (tb_is_last),
    .byte_num    (tb_byte_num),
    .buffer_full (tb_buffer_full),
    .out         (tb_out),
    .out_ready   (tb_out_ready),
    .f_ack       (tb_f_ack),
    .done        (tb_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] word;
    logic [2:0]  bn;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a falling edge; offers one word for exactly one rising edge.
  task automatic send_word(input logic [63:0] w, input logic l, input logic [2:0] b);
    tb_in       = w;
    tb_in_ready = 1'b1;
    tb_is_last  = l;
    tb_byte_num = b;
    @(posedge clk);
    @(negedge clk);
    tb_in_ready = 1'b0;
    tb_is_last  = 1'b0;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!tb_out_ready && n < 100) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
  endtask

  task automatic pulse_ack();
    tb_f_ack = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tb_f_ack = 1'b0;
  endtask

  task automatic apply_reset();
    tb_reset = 1'b1;
    @(negedge clk);
    tb_reset = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    tb_reset    = 1'b1;
    tb_in       = '0;
    tb_in_ready = 1'b0;
    tb_is_last  = 1'b0;
    tb_byte_num = '0;
    tb_f_ack    = 1'b0;

    vecs[0] = '{64'h6162_63FF_FFFF_FFFF, 3'd3, 64'h6162_6301_0000_0000};
    vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 3'd0, 64'h0100_0000_0000_0000};
    vecs[2] = '{64'h0102_0304_0506_0708, 3'd7, 64'h0102_0304_0506_0701};
    vecs[3] = '{64'hDEAD_BEEF_CAFE_BABE, 3'd5, 64'hDEAD_BEEF_CA01_0000};
    vecs[4] = '{64'h1122_3344_5566_7788, 3'd1, 64'h1101_0000_0000_0000};
    vecs[5] = '{64'hAABB_CCDD_EEFF_0011, 3'd6, 64'hAABB_CCDD_EEFF_0100};
    vecs[6] = '{64'h1234_5678_9ABC_DEF0, 3'd2, 64'h1234_0100_0000_0000};
    vecs[7] = '{64'hCCCC_CCCC_CCCC_CCCC, 3'd4, 64'hCCCC_CCCC_0100_0000};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_out_ready", 64'(tb_out_ready), 64'd0);
    check("rst_done", 64'(tb_done), 64'd0);
    check("rst_buffer_full", 64'(tb_buffer_full), 64'd0);
    check("rst_out_zero", 64'(|tb_out), 64'd0);
    tb_reset = 1'b0;

    // Single-word messages: latency, masking, pad bytes, done
    for (int i = 0; i < 8; i++) begin
      apply_reset();
      send_word(vecs[i].word, 1'b1, vecs[i].bn);
      check("zf_buffer_full", 64'(tb_buffer_full), 64'd1);
      wait_ready(n);
      check("one_word_latency", 64'(n), 64'd16);
      check("one_word_top", tb_out[1087 -: 64], vecs[i].exp);
      check("one_word_low", 64'(tb_out[7:0]), 64'h80);
      check("one_word_mid_zero", 64'(|tb_out[1023:8]), 64'd0);
      pulse_ack();
      check("one_word_done", 64'(tb_done), 64'd1);
      check("one_word_done_ready", 64'(tb_out_ready), 64'd0);
      check("one_word_done_full", 64'(tb_buffer_full), 64'd1);
    end

    // 136-byte message with backpressure on the first block
    apply_reset();
    for (int i = 0; i < 17; i++) send_word(ONES1, 1'b0, 3'd0);
    wait_ready(n);
    check("b136_latency", 64'(n), 64'd0);
    for (int i = 0; i < 17; i++) check("b136_word", tb_out[1087-64*i -: 64], ONES1);
    tb_in       = 64'hFFFF_FFFF_FFFF_FFFF;
    tb_in_ready = 1'b1;
    tb_is_last  = 1'b1;
    tb_byte_num = 3'd0;
    repeat (5) begin
      @(posedge clk);
      @(negedge clk);
      check("bp_out_ready", 64'(tb_out_ready), 64'd1);
      check("bp_buffer_full", 64'(tb_buffer_full), 64'd1);
      check("bp_out_stable", 64'(tb_out == {17{ONES1}}), 64'd1);
    end
    pulse_ack();
    check("ack_out_ready", 64'(tb_out_ready), 64'd0);
    check("ack_out_clear", 64'(|tb_out), 64'd0);
    check("ack_buffer_free", 64'(tb_buffer_full), 64'd0);
    @(posedge clk);
    @(negedge clk);
    tb_in_ready = 1'b0;
    tb_is_last  = 1'b0;
    check("b136_second_zf", 64'(tb_buffer_full), 64'd1);
    wait_ready(n);
    check("b136_second_latency", 64'(n), 64'd16);
    check("b136_second_top", tb_out[1087 -: 64], 64'h0100_0000_0000_0000);
    check("b136_second_low", 64'(tb_out[7:0]), 64'h80);
    check("b136_second_mid", 64'(|tb_out[1023:8]), 64'd0);
    pulse_ack();
    check("b136_done", 64'(tb_done), 64'd1);

    // 135-byte message: last word is word 16 with byte_num=7
    apply_reset();
    for (int i = 0; i < 16; i++) send_word(64'(i) * 64'h0101_0101_0101_0101, 1'b0, 3'd0);
    send_word(64'hAABB_CCDD_EEFF_1122, 1'b1, 3'd7);
    wait_ready(n);
    check("b135_latency", 64'(n), 64'd0);
    check("b135_low_byte", 64'(tb_out[7:0]), 64'h81);
    check("b135_last_word", tb_out[63:0], 64'hAABB_CCDD_EEFF_1181);
    check("b135_word0", tb_out[1087 -: 64], 64'h0);
    check("b135_word5", tb_out[1087-64*5 -: 64], 64'h0505_0505_0505_0505);
    check("b135_word15", tb_out[1087-64*15 -: 64], 64'h0F0F_0F0F_0F0F_0F0F);
    pulse_ack();
    check("b135_done", 64'(tb_done), 64'd1);

    // Async reset in the middle of zero fill, then a fresh "abc"
    apply_reset();
    send_word(64'h6162_63FF_FFFF_FFFF, 1'b1, 3'd3);
    tb_f_ack = 1'b1;
    @(posedge clk);
    #1;
    tb_f_ack = 1'b0;
    check("zf_ack_ignored", 64'(tb_out_ready), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("zf_pre_reset_full", 64'(tb_buffer_full), 64'd1);
    check("zf_pre_reset_data", 64'(|tb_out), 64'd1);
    #1;
    tb_reset = 1'b1;
    #1;
    check("arst_out", 64'(|tb_out), 64'd0);
    check("arst_out_ready", 64'(tb_out_ready), 64'd0);
    check("arst_done", 64'(tb_done), 64'd0);
    check("arst_buffer_full", 64'(tb_buffer_full), 64'd0);
    @(negedge clk);
    tb_reset = 1'b0;
    send_word(64'h6162_63FF_FFFF_FFFF, 1'b1, 3'd3);
    wait_ready(n);
    check("abc_again_latency", 64'(n), 64'd16);
    check("abc_again_top", tb_out[1087 -: 64], 64'h6162_6301_0000_0000);
    check("abc_again_low", 64'(tb_out[7:0]), 64'h80);
    check("abc_again_mid", 64'(|tb_out[1023:8]), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/keccak_padder.md
Name: keccak_padder

Overview:
- Producer side of the permutation's absorb handshake. It packs a stream of 64-bit message words into RATE-bit blocks and applies Keccak multi-rate padding.
- Each complete block is presented on out/out_ready, and the block is held until the permutation returns f_ack.
- Sits between the message source and the f-permutation core. It drives the core's in/in_ready and consumes its ack.
- One-shot per message: after the final padded block is acked, done is raised and the block idles until reset.

Parameters:
- RATE, 1088: block width in bits; must be a multiple of 64. Default gives 17 words per block (Keccak-256).
- PAD_BYTE, 8'h01: domain/pad-start byte. 8'h01 is original Keccak; 8'h06 is SHA3.

Ports:
- clk  in  1  clock, all state on the rising edge.
- reset  in  1  asynchronous, active-high.
- in  in  64  message word. Byte 0 is in[63:56], byte 7 is in[7:0].
- in_ready  in  1  source offers a word this cycle.
- is_last  in  1  qualifies in_ready; this word is the final, partial word.
- byte_num  in  3  when is_last: number of valid bytes (0..7) in this word. Ignored otherwise.
- buffer_full  out  1  high means the word offered this cycle is NOT taken.
- out  out  RATE  padded block. Word 0 (first accepted) is at out[RATE-1:RATE-64].
- out_ready  out  1  out holds a complete block.
- f_ack  in  1  permutation consumed out this cycle.
- done  out  1  final block acked; sticky until reset.

Behaviour:
- Reset (async): state=FILL, word count cnt=0, out=0, out_ready=0, done=0, buffer_full=0.
- A word is accepted when in_ready & ~buffer_full. Every accepted word shifts in: out <= {out[RATE-65:0], word}, and cnt increments.
- buffer_full is combinational: it is 1 in every state except FILL. buffer_full is 0 in FILL.
- A full word must never be sent with is_last. A message whose length is a multiple of 8 bytes ends with is_last=1, byte_num=0. Consequently, padding always fits in the current block and no extra block is ever generated.
- Last-word transform, done by sub-module keccak_pad_word:
  - bytes 0..byte_num-1 pass through;
  - byte[byte_num] = PAD_BYTE;
  - all higher bytes = 0.
- The final 0x80 is ORed into out[7:0] when the block completes after a last word. If byte_num=7 and this is word RATE/64-1, out[7:0] = PAD_BYTE|8'h80 (8'h81 for default).
- FILL state:
  - Non-last accept with cnt==RATE/64-1: go to FULL, cnt=0, out_ready=1 next cycle.
  - Last accept with cnt==RATE/64-1: go to FULL, set the 0x80 bit, set the last_blk flag.
  - Last accept with cnt<RATE/64-1: go to ZERO_FILL, set the last_blk flag.
  - Otherwise stay in FILL.
- ZERO_FILL state:
  - Each cycle shifts in 64'h0 and increments cnt. No input is accepted.
  - When the shifted-in word is index RATE/64-1, OR 0x80 into its low byte, go to FULL, cnt=0.
  - A last word at index k therefore spends RATE/64-1-k cycles here.
- FULL state:
  - out_ready=1 and out is stable. in_ready is ignored.
  - On f_ack: out_ready=0 and out is cleared to 0.
    - If last_blk is clear, go to FILL (a word can be accepted the cycle after).
    - If last_blk is set, go to DONE.
- DONE state: done=1, buffer_full=1, out_ready=0. Stays here until reset.
- f_ack outside FULL is ignored.
- Latency: the 17th word accepted at cycle t gives out_ready at t+1. An empty message offered at t gives out_ready at t+17.
- Reset asserted in any state, including mid-ZERO_FILL or mid-FULL: immediate return to reset values; the partial block is discarded.

Decomposition:
- Shared package keccak_pkg holds:
  - K_RATE, K_WORDS=K_RATE/64;
  - PAD_KECCAK=8'h01, PAD_SHA3=8'h06, PAD_END=8'h80;
  - the state encoding FILL/ZERO_FILL/FULL/DONE.
- One combinational sub-module, keccak_pad_word (in, byte_num, PAD_BYTE -> padded word), for byte masking and pad-byte insertion.
- Everything else (the FSM, counter, shift register and last_blk flag) stays in keccak_padder.

Test Plan:
- Empty message: is_last=1, byte_num=0 at cycle 0.
  - Expect out_ready at cycle 17; out[1087:1080]=8'h01, out[7:0]=8'h80, all other bits 0.
  - Pulse f_ack: done=1 the next cycle.
- "abc": in=64'h6162_63FF_FFFF_FFFF, is_last=1, byte_num=3.
  - Expect out[1087:1024]=64'h6162_6301_0000_0000 (garbage bytes masked) and out[7:0]=8'h80.
- 136-byte message: 17 non-last words 64'h1111..11, then is_last with byte_num=0.
  - First block: all 17 words equal 64'h1111..11.
  - buffer_full=1 until f_ack.
  - Second block: out[1087:1080]=8'h01, out[7:0]=8'h80.
- 135-byte message: 16 words, then word 16 with is_last, byte_num=7, in=64'hAABB..GG.
  - Expect no ZERO_FILL cycles and out[7:0]=8'h81.
- Backpressure: keep in_ready=1 during FULL and hold f_ack low 5 cycles.
  - out and out_ready stay stable and cnt does not move.
  - The word offered after f_ack is accepted as word 0 of the next block.
- Async reset pulsed mid-ZERO_FILL (3 cycles after the last word).
  - out=0, out_ready=0, done=0 immediately.
  - A fresh "abc" message then produces the same block as the "abc" test.
